keypad_digit_entry: RTL and testbench

Consumer of the keypad priority encoder's BCD code and active-low valid flag. Debounces each key press, accepts exactly one digit per press, and right-shifts the digits into a 4-digit MM:SS setting register. On a start request it validates the entry and hands it to the timer with a one-cycle load pulse. It sits between the keypad encoder and the countdown timer in the timer-input/control path.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/stable_counter.sv | 34 +++
 rtl/keypad_digit_entry.sv | 140 ++++++++++++++
 tb/tb_keypad_digit_entry.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for keypad digit entry.
// Digit slices are little-end first: secUnits in [3:0].
package keypad_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESS_DEB,
      HELD,
      REL_DEB,
      COMMIT
   } state_t;

   localparam logic [3:0] BCD_MAX      = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;
   localparam logic [2:0] NUM_DIGITS   = 3'd4;

   localparam int DIGIT_W      = 4;
   localparam int SEC_UNITS_LO = 0;
   localparam int SEC_TENS_LO  = 4;
   localparam int MIN_UNITS_LO = 8;
   localparam int MIN_TENS_LO  = 12;

endpackage

// File: rtl/stable_counter.sv
// Saturating stability counter shared by press and release debounce.
// done means the next increment reaches DEBOUNCE_CYCLES.
module stable_counter #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   input  logic clear,
   input  logic inc,
   output logic done
);

   localparam logic [CNT_W-1:0] TOP  = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (restart) begin
         count <= CNT_W'(1);
      end else if (inc && count != TOP) begin
         count <= count + CNT_W'(1);
      end
   end

   assign done = (count >= LAST);

endmodule

// File: rtl/keypad_digit_entry.sv
// Debounced keypad digit entry into an MM:SS setting register.
// Commits to the timer with a one-cycle load pulse.
module keypad_digit_entry
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  bcdIn,
   input  logic        dataValn,
   input  logic        entryEn,
   input  logic        clear,
   input  logic        start,
   output logic [15:0] digits,
   output logic [2:0]  digitCount,
   output logic        keyStrobe,
   output logic        loadTime,
   output logic        entryErr
);

   state_t      state_q, state_d;
   logic [3:0]  cand_q, cand_d;
   logic [15:0] digits_d;
   logic [2:0]  count_d;
   logic        strobe_d, load_d, err_d;
   logic        cnt_restart, cnt_clear, cnt_inc, deb_done;
   logic [3:0]  sec_tens;

   assign sec_tens = digits[SEC_TENS_LO +: DIGIT_W];

   stable_counter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
   ) u_deb (
      .clk    (clk),
      .rst    (rst),
      .restart(cnt_restart),
      .clear  (cnt_clear),
      .inc    (cnt_inc),
      .done   (deb_done)
   );

   always_comb begin
      state_d     = state_q;
      cand_d      = cand_q;
      digits_d    = digits;
      count_d     = digitCount;
      strobe_d    = 1'b0;
      load_d      = 1'b0;
      err_d       = 1'b0;
      cnt_restart = 1'b0;
      cnt_clear   = 1'b0;
      cnt_inc     = 1'b0;
      if (clear) begin
         digits_d  = '0;
         count_d   = '0;
         cnt_clear = 1'b1;
         // a key still down must be released before it counts again
         state_d   = dataValn ? IDLE : HELD;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start && digitCount != 3'd0) begin
                  state_d = COMMIT;
                  if (sec_tens <= SEC_TENS_MAX) load_d = 1'b1;
                  else                          err_d  = 1'b1;
               end else if (!dataValn && entryEn) begin
                  state_d     = PRESS_DEB;
                  cand_d      = bcdIn;
                  cnt_restart = 1'b1;
               end
            end
            PRESS_DEB: begin
               if (dataValn || bcdIn != cand_q || !entryEn) begin
                  state_d   = IDLE;
                  cnt_clear = 1'b1;
               end else if (deb_done) begin
                  state_d   = HELD;
                  cnt_clear = 1'b1;
                  if (cand_q <= BCD_MAX && digitCount < NUM_DIGITS) begin
                     digits_d = {digits[MIN_TENS_LO-1:0], cand_q};
                     count_d  = digitCount + 3'd1;
                     strobe_d = 1'b1;
                  end
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            HELD: begin
               if (dataValn) begin
                  state_d     = REL_DEB;
                  cnt_restart = 1'b1;
               end
            end
            REL_DEB: begin
               if (!dataValn) begin
                  state_d   = HELD;
                  cnt_clear = 1'b1;
               end else if (deb_done) begin
                  state_d   = IDLE;
                  cnt_clear = 1'b1;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
            COMMIT: begin
               digits_d = '0;
               count_d  = '0;
               state_d  = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cand_q     <= '0;
         digits     <= '0;
         digitCount <= '0;
         keyStrobe  <= 1'b0;
         loadTime   <= 1'b0;
         entryErr   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cand_q     <= cand_d;
         digits     <= digits_d;
         digitCount <= count_d;
         keyStrobe  <= strobe_d;
         loadTime   <= load_d;
         entryErr   <= err_d;
      end
   end

endmodule

// File: tb/tb_keypad_digit_entry.sv
// Directed bench for keypad_digit_entry with a queue-based reference model.
// Outputs are compared against the model on every falling edge.
module tb_keypad_digit_entry;

   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  bcdIn = 4'd0;
   logic        dataValn = 1'b1;
   logic        entryEn = 1'b1;
   logic        clear = 1'b0;
   logic        start = 1'b0;
   logic [15:0] digits;
   logic [2:0]  digitCount;
   logic        keyStrobe, loadTime, entryErr;

   int vec = 0;
   int miss = 0;
   int nstrobe = 0;

   keypad_digit_entry #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk       (clk),
      .rst       (rst),
      .bcdIn     (bcdIn),
      .dataValn  (dataValn),
      .entryEn   (entryEn),
      .clear     (clear),
      .start     (start),
      .digits    (digits),
      .digitCount(digitCount),
      .keyStrobe (keyStrobe),
      .loadTime  (loadTime),
      .entryErr  (entryErr)
   );

   always #5 clk = ~clk;

   // reference model: entered digits as a queue, plus run lengths
   int   q[$];
   bit   armed;
   int   run;
   int   cand;
   bit   committing;
   logic e_strobe, e_load, e_err;

   function automatic logic [15:0] packed_digits();
      logic [15:0] v = '0;
      foreach (q[i]) v = (v << 4) | 16'(q[i]);
      return v;
   endfunction

   function automatic int sec_tens();
      return (q.size() >= 2) ? q[q.size()-2] : 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         armed = 1; run = 0; cand = 0; committing = 0;
         e_strobe = 0; e_load = 0; e_err = 0;
      end else begin
         e_strobe = 0; e_load = 0; e_err = 0;
         if (clear) begin
            q.delete();
            run = 0; committing = 0;
            armed = dataValn;
         end else if (committing) begin
            q.delete();
            committing = 0;
         end else if (armed && run == 0) begin
            if (start && q.size() > 0) begin
               committing = 1;
               if (sec_tens() <= 5) e_load = 1;
               else                 e_err = 1;
            end else if (!dataValn && entryEn) begin
               run = 1;
               cand = int'(bcdIn);
            end
         end else if (armed) begin
            if (dataValn || int'(bcdIn) != cand || !entryEn) begin
               run = 0;
            end else begin
               run++;
               if (run == DEB) begin
                  if (cand <= 9 && q.size() < 4) begin
                     q.push_back(cand);
                     e_strobe = 1;
                  end
                  armed = 0;
                  run = 0;
               end
            end
         end else begin
            if (dataValn) begin
               run++;
               if (run == DEB) begin
                  armed = 1;
                  run = 0;
               end
            end else begin
               run = 0;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (keyStrobe) nstrobe++;
      chk("cycle", {10'd0, digits, digitCount, keyStrobe, loadTime, entryErr},
          {10'd0, packed_digits(), 3'(q.size()), e_strobe, e_load, e_err});
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic key(input logic [3:0] code, input int hold, input int rel);
      @(negedge clk);
      dataValn = 1'b0;
      bcdIn = code;
      cyc(hold);
      dataValn = 1'b1;
      cyc(rel);
   endtask

   int s0;

   initial begin
      cyc(2);
      chk("reset_digits", {16'd0, digits}, 32'h0);
      chk("reset_count", {29'd0, digitCount}, 32'h0);
      #1 rst = 1'b0;
      cyc(2);

      // start with nothing entered is ignored
      start = 1'b1;
      @(posedge clk); #1;
      chk("empty_start", {30'd0, loadTime, entryErr}, 32'h0);
      @(negedge clk); start = 1'b0;
      cyc(2);

      // press 5 for 10 cycles: strobe exactly in cycle DEB
      s0 = nstrobe;
      bcdIn = 4'd5; dataValn = 1'b0;
      repeat (DEB - 1) @(posedge clk);
      #1 chk("press_early", {31'd0, keyStrobe}, 32'h0);
      @(posedge clk);
      #1 chk("press_strobe", {31'd0, keyStrobe}, 32'h1);
      chk("press_digits", {16'd0, digits}, 32'h0005);
      repeat (10 - DEB) @(posedge clk);
      @(negedge clk); dataValn = 1'b1;
      cyc(6);
      chk("press_once", nstrobe - s0, 1);
      chk("press_count", {29'd0, digitCount}, 32'd1);

      // code bounce 3 -> 8 -> 3
      s0 = nstrobe;
      @(negedge clk); dataValn = 1'b0; bcdIn = 4'd3;
      @(negedge clk); bcdIn = 4'd8;
      @(negedge clk); bcdIn = 4'd3;
      cyc(6);
      dataValn = 1'b1;
      cyc(6);
      chk("bounce_once", nstrobe - s0, 1);
      chk("bounce_digits", {16'd0, digits}, 32'h0053);

      // 1,3,0 then commit
      @(negedge clk); clear = 1'b1;
      @(negedge clk); clear = 1'b0;
      key(4'd1, 6, 6); key(4'd3, 6, 6); key(4'd0, 6, 6);
      chk("e130_digits", {16'd0, digits}, 32'h0130);
      start = 1'b1;
      @(posedge clk); #1;
      chk("e130_load", {30'd0, loadTime, entryErr}, 32'h2);
      chk("e130_hold", {16'd0, digits}, 32'h0130);
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      chk("e130_cleared", {13'd0, digits, digitCount}, 32'h0);
      chk("e130_pulse", {31'd0, loadTime}, 32'h0);
      cyc(2);

      // five keys: fifth rejected
      s0 = nstrobe;
      key(4'd1, 6, 6); key(4'd2, 6, 6); key(4'd3, 6, 6);
      key(4'd4, 6, 6); key(4'd5, 6, 6);
      chk("full_strobes", nstrobe - s0, 4);
      chk("full_digits", {16'd0, digits}, 32'h1234);
      chk("full_count", {29'd0, digitCount}, 32'd4);
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1;
      chk("full_load", {30'd0, loadTime, entryErr}, 32'h2);
      @(negedge clk); start = 1'b0;
      cyc(3);

      // seconds tens of 7 rejected
      key(4'd1, 6, 6); key(4'd7, 6, 6); key(4'd0, 6, 6);
      chk("err_digits", {16'd0, digits}, 32'h0170);
      start = 1'b1;
      @(posedge clk); #1;
      chk("err_pulse", {30'd0, loadTime, entryErr}, 32'h1);
      @(negedge clk); start = 1'b0;
      @(posedge clk); #1;
      chk("err_cleared", {13'd0, digits, digitCount}, 32'h0);
      cyc(2);

      // release bounce gives no second strobe
      s0 = nstrobe;
      @(negedge clk); dataValn = 1'b0; bcdIn = 4'd2;
      cyc(6);
      dataValn = 1'b1; cyc(2);
      dataValn = 1'b0; cyc(1);
      dataValn = 1'b1; cyc(6);
      chk("relbounce_once", nstrobe - s0, 1);
      chk("relbounce_digits", {16'd0, digits}, 32'h0002);

      // clear while a key is held: no re-accept until re-press
      @(negedge clk); dataValn = 1'b0; bcdIn = 4'd4;
      cyc(6);
      chk("held_digits", {16'd0, digits}, 32'h0024);
      clear = 1'b1; cyc(1); clear = 1'b0;
      s0 = nstrobe;
      cyc(8);
      chk("clear_noaccept", nstrobe - s0, 0);
      chk("clear_digits", {13'd0, digits, digitCount}, 32'h0);
      dataValn = 1'b1; cyc(6);
      key(4'd6, 6, 6);
      chk("repress_digits", {16'd0, digits}, 32'h0006);

      // entry disabled, then invalid code, then reset mid-debounce
      s0 = nstrobe;
      entryEn = 1'b0;
      key(4'd8, 6, 6);
      entryEn = 1'b1;
      key(4'd12, 6, 6);
      @(negedge clk); dataValn = 1'b0; bcdIn = 4'd7;
      cyc(2);
      #1 rst = 1'b1;
      @(negedge clk); dataValn = 1'b1;
      #1 rst = 1'b0;
      cyc(6);
      chk("misc_nostrobe", nstrobe - s0, 0);
      chk("reset_mid", {13'd0, digits, digitCount}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule
